// File: rtl/io_port_bridge.sv
// Peripheral I/O stage behind the CPU core: strobed output registers, a combinational
// read mux, synchronized switches, and debounced buttons driving a maskable interrupt.
module io_port_bridge #(
    parameter logic [7:0] LED_PORT      = 8'h40,
    parameter logic [7:0] SSEG_PORT     = 8'h81,
    parameter logic [7:0] SW_PORT       = 8'h20,
    parameter logic [7:0] BTN_PORT      = 8'h24,
    parameter logic [7:0] INT_MASK_PORT = 8'h25,
    parameter logic [7:0] INT_ACK_PORT  = 8'h26,
    parameter int         DEB_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_strb,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    input  logic [7:0] switches,
    input  logic [3:0] buttons,
    output logic [7:0] leds,
    output logic [7:0] sseg_val,
    output logic       interrupt
);

    localparam int            CW      = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [7:0]    sw_meta, sw_sync;
    logic [3:0]    btn_meta, btn_sync;
    logic [3:0]    debounced, deb_q, pending, mask;
    logic [3:0]    ack_clr, rise;
    logic [CW-1:0] cnt [4];

    // io_strb qualifies port_id/out_port for exactly one cycle; there is no ready,
    // every strobed write is accepted on the edge where io_strb is high.
    always_comb begin
        ack_clr = 4'h0;
        if (io_strb && port_id == INT_ACK_PORT) ack_clr = out_port[3:0];
    end

    assign rise = debounced & ~deb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds     <= 8'h00;
            sseg_val <= 8'h00;
            mask     <= 4'h0;
        end else if (io_strb) begin
            if (port_id == LED_PORT)      leds     <= out_port;
            if (port_id == SSEG_PORT)     sseg_val <= out_port;
            if (port_id == INT_MASK_PORT) mask     <= out_port[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta  <= 8'h00;
            sw_sync  <= 8'h00;
            btn_meta <= 4'h0;
            btn_sync <= 4'h0;
        end else begin
            sw_meta  <= switches;
            sw_sync  <= sw_meta;
            btn_meta <= buttons;
            btn_sync <= btn_meta;
        end
    end

    // A level is accepted only after DEB_CYCLES consecutive disagreeing samples;
    // a single agreeing sample restarts the count, for press and release alike.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            debounced <= 4'h0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_sync[i] != debounced[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        debounced[i] <= btn_sync[i];
                        cnt[i]       <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Rise is OR-ed after the clear so a same-edge acknowledge cannot lose a new press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_q     <= 4'h0;
            pending   <= 4'h0;
            interrupt <= 1'b0;
        end else begin
            deb_q     <= debounced;
            pending   <= (pending & ~ack_clr) | rise;
            interrupt <= |(pending & mask);
        end
    end

    always_comb begin
        in_port = 8'h00;
        case (port_id)
            SW_PORT:       in_port = sw_sync;
            BTN_PORT:      in_port = {pending, debounced};
            LED_PORT:      in_port = leds;
            SSEG_PORT:     in_port = sseg_val;
            INT_MASK_PORT: in_port = {4'h0, mask};
            default:       in_port = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: vector table for the write/read path, hand sequences for
// debounce/mask/ack/collision/reset, and randomized traffic against a behavioural model.
module tb_io_port_bridge;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       io_strb = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic [7:0] in_port;
    logic [7:0] switches = 8'h00;
    logic [3:0] buttons = 4'h0;
    logic [7:0] leds;
    logic [7:0] sseg_val;
    logic       interrupt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    io_port_bridge #(.DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .io_strb(io_strb), .port_id(port_id),
        .out_port(out_port), .in_port(in_port), .switches(switches),
        .buttons(buttons), .leds(leds), .sseg_val(sseg_val), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] p, input logic [7:0] d);
        io_strb  = 1'b1;
        port_id  = p;
        out_port = d;
        tick();
        io_strb  = 1'b0;
        port_id  = 8'h00;
        out_port = 8'h00;
    endtask

    task automatic rd_check(input string name, input logic [7:0] p, input logic [7:0] exp);
        port_id = p;
        #1;
        check(name, in_port, exp);
    endtask

    typedef struct {
        logic       strb;
        logic [7:0] port;
        logic [7:0] data;
        logic [7:0] rd_port;
        logic [7:0] exp_rd;
        logic [7:0] exp_leds;
        logic [7:0] exp_sseg;
    } vec_t;

    vec_t vecs[9];

    // Behavioural model of the register file seen through the read port.
    logic [7:0] m_leds, m_sseg, m_sw;
    logic [3:0] m_mask, exp_pend;

    function automatic logic [7:0] model_read(input logic [7:0] p);
        if (p == 8'h20) return m_sw;
        if (p == 8'h24) return 8'h00;
        if (p == 8'h40) return m_leds;
        if (p == 8'h81) return m_sseg;
        if (p == 8'h25) return {4'h0, m_mask};
        return 8'h00;
    endfunction

    function automatic logic [7:0] pick_port();
        logic [7:0] tbl [8];
        tbl = '{8'h40, 8'h81, 8'h20, 8'h24, 8'h25, 8'h26, 8'h41, 8'h00};
        tbl[7] = 8'($urandom);
        return tbl[$urandom_range(0, 7)];
    endfunction

    initial begin
        // Reset state
        #1;
        check("rst_leds", leds, 8'h00);
        check("rst_sseg", sseg_val, 8'h00);
        check("rst_int", {7'h0, interrupt}, 8'h00);
        rd_check("rst_btn", 8'h24, 8'h00);
        #3 rst = 1'b1;
        tick();

        // Write/read vector table
        vecs[0] = '{1'b1, 8'h40, 8'h3C, 8'h40, 8'h3C, 8'h3C, 8'h00};
        vecs[1] = '{1'b1, 8'h41, 8'hFF, 8'h40, 8'h3C, 8'h3C, 8'h00};
        vecs[2] = '{1'b0, 8'h40, 8'h77, 8'h40, 8'h3C, 8'h3C, 8'h00};
        vecs[3] = '{1'b1, 8'h81, 8'h5A, 8'h81, 8'h5A, 8'h3C, 8'h5A};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h99, 8'h00, 8'h3C, 8'h5A};
        vecs[5] = '{1'b1, 8'h25, 8'hFE, 8'h25, 8'h0E, 8'h3C, 8'h5A};
        vecs[6] = '{1'b1, 8'h20, 8'h12, 8'h20, 8'h00, 8'h3C, 8'h5A};
        vecs[7] = '{1'b1, 8'h25, 8'h00, 8'h25, 8'h00, 8'h3C, 8'h5A};
        vecs[8] = '{1'b1, 8'h26, 8'hFF, 8'h24, 8'h00, 8'h3C, 8'h5A};
        for (int i = 0; i < 9; i++) begin
            io_strb  = vecs[i].strb;
            port_id  = vecs[i].port;
            out_port = vecs[i].data;
            tick();
            io_strb = 1'b0;
            rd_check($sformatf("vec%0d_rd", i), vecs[i].rd_port, vecs[i].exp_rd);
            check($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
            check($sformatf("vec%0d_sseg", i), sseg_val, vecs[i].exp_sseg);
        end

        // Switch synchronizer latency
        switches = 8'hA7;
        tick();
        rd_check("sw_edge1", 8'h20, 8'h00);
        tick();
        rd_check("sw_edge2", 8'h20, 8'hA7);

        // Randomized register traffic against the model
        m_leds = 8'h3C; m_sseg = 8'h5A; m_mask = 4'h0;
        for (int it = 0; it < 40; it++) begin
            logic [7:0] p, d, rp;
            m_sw = 8'($urandom);
            switches = m_sw;
            p = pick_port();
            d = 8'($urandom);
            do_write(p, d);
            if (p == 8'h40) m_leds = d;
            if (p == 8'h81) m_sseg = d;
            if (p == 8'h25) m_mask = d[3:0];
            tick();
            rp = pick_port();
            exp_q.push_back(model_read(rp));
            port_id = rp;
            #1;
            check("rand_rd", in_port, exp_q.pop_front());
            check("rand_leds", leds, m_leds);
            check("rand_int", {7'h0, interrupt}, 8'h00);
        end

        // Debounce timing: interrupt on the 8th edge after a held press
        do_write(8'h25, 8'h01);
        buttons = 4'h1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 5) rd_check("deb_e5", 8'h24, 8'h00);
            if (e == 6) rd_check("deb_e6", 8'h24, 8'h01);
            if (e == 7) begin
                rd_check("deb_e7", 8'h24, 8'h11);
                check("int_e7", {7'h0, interrupt}, 8'h00);
            end
            if (e == 8) check("int_e8", {7'h0, interrupt}, 8'h01);
        end

        // 3-cycle glitch on button 1 never qualifies; release of button 0 sets nothing
        buttons = 4'h2;
        repeat (3) tick();
        buttons = 4'h0;
        for (int e = 0; e < 12; e++) begin
            tick();
            port_id = 8'h24;
            #1;
            check("glitch_b1", in_port & 8'h22, 8'h00);
        end
        rd_check("release_btn", 8'h24, 8'h10);
        check("release_int", {7'h0, interrupt}, 8'h01);

        // Mask: masked pending stays latched, unmasking raises interrupt
        do_write(8'h26, 8'h0F);
        do_write(8'h25, 8'h00);
        tick();
        check("mask_idle_int", {7'h0, interrupt}, 8'h00);
        buttons = 4'h4;
        repeat (10) tick();
        rd_check("mask_btn", 8'h24, 8'h44);
        check("mask_int0", {7'h0, interrupt}, 8'h00);
        do_write(8'h25, 8'h04);
        check("unmask_same", {7'h0, interrupt}, 8'h00);
        tick();
        check("unmask_next", {7'h0, interrupt}, 8'h01);

        // Acknowledge
        buttons = 4'h5;
        repeat (10) tick();
        rd_check("ack_pre", 8'h24, 8'h55);
        do_write(8'h25, 8'h05);
        tick();
        do_write(8'h26, 8'h01);
        rd_check("ack1_btn", 8'h24, 8'h45);
        check("ack1_int_a", {7'h0, interrupt}, 8'h01);
        tick();
        check("ack1_int_b", {7'h0, interrupt}, 8'h01);
        do_write(8'h26, 8'h04);
        rd_check("ack4_btn", 8'h24, 8'h05);
        check("ack4_int_lag", {7'h0, interrupt}, 8'h01);
        tick();
        check("ack4_int_drop", {7'h0, interrupt}, 8'h00);

        // Collision: acknowledge lands on the edge the rise is registered
        buttons = 4'h0;
        repeat (10) tick();
        rd_check("col_pre", 8'h24, 8'h00);
        do_write(8'h25, 8'h01);
        buttons = 4'h1;
        repeat (6) tick();
        rd_check("col_deb", 8'h24, 8'h01);
        do_write(8'h26, 8'h01);
        rd_check("col_pend", 8'h24, 8'h11);
        tick();
        check("col_int_a", {7'h0, interrupt}, 8'h01);
        tick();
        check("col_int_b", {7'h0, interrupt}, 8'h01);

        // Randomized button pulses: a pulse qualifies iff it lasts DEB cycles or more
        buttons = 4'h0;
        repeat (10) tick();
        do_write(8'h26, 8'h0F);
        m_mask = 4'($urandom);
        do_write(8'h25, {4'h0, m_mask});
        tick();
        exp_pend = 4'h0;
        for (int it = 0; it < 12; it++) begin
            int b, len;
            b = $urandom_range(0, 3);
            len = $urandom_range(1, 7);
            buttons[b] = 1'b1;
            repeat (len) tick();
            buttons = 4'h0;
            repeat (14) tick();
            if (len >= DEB) exp_pend[b] = 1'b1;
            rd_check("pulse_btn", 8'h24, {exp_pend, 4'h0});
            check("pulse_int", {7'h0, interrupt}, {7'h0, |(exp_pend & m_mask)});
            if (it % 4 == 3) begin
                logic [3:0] a;
                a = 4'($urandom);
                do_write(8'h26, {4'h0, a});
                exp_pend = exp_pend & ~a;
                tick();
                rd_check("pulse_ack_btn", 8'h24, {exp_pend, 4'h0});
                check("pulse_ack_int", {7'h0, interrupt}, {7'h0, |(exp_pend & m_mask)});
            end
        end

        // Asynchronous reset mid-operation, then re-qualification of held buttons
        do_write(8'h40, 8'hA5);
        do_write(8'h25, 8'h0F);
        buttons = 4'hF;
        repeat (10) tick();
        rd_check("prerst_btn", 8'h24, 8'hFF);
        check("prerst_leds", leds, 8'hA5);
        #2 rst = 1'b0;
        #1;
        check("arst_leds", leds, 8'h00);
        check("arst_sseg", sseg_val, 8'h00);
        check("arst_int", {7'h0, interrupt}, 8'h00);
        rd_check("arst_btn", 8'h24, 8'h00);
        rd_check("arst_mask", 8'h25, 8'h00);
        #1 rst = 1'b1;
        repeat (5) tick();
        rd_check("requal_e5", 8'h24, 8'h00);
        repeat (2) tick();
        rd_check("requal_e7", 8'h24, 8'hF0 | 8'h0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
